// File: rtl/p405s_itlb_refill_ctl.sv
// Instruction shadow-TLB refill sequencer: requests the UTLB on a qualified miss,
// writes the returned translation into the round-robin victim word, or reports a fault.
module p405s_itlb_refill_ctl #(
  parameter int EPN_W   = 22,
  parameter int DSIZE_W = 7,
  parameter int TO_CYC  = 31
) (
  input  logic               CB,
  input  logic               coreReset_N,
  input  logic               itlbMiss,
  input  logic               ifetchValid,
  input  logic               msrIR,
  input  logic [EPN_W-1:0]   fetchEPN,
  input  logic               isAbort,
  input  logic               isInvalidate,
  output logic               utlbReq,
  input  logic               utlbGnt,
  output logic [EPN_W-1:0]   utlbEPN,
  input  logic               utlbRspVld,
  input  logic               utlbHit,
  input  logic               utlbEX,
  input  logic [EPN_W-1:0]   utlbRPN,
  input  logic [DSIZE_W-1:0] utlbDSize,
  input  logic               utlbE,
  input  logic               utlbI,
  input  logic               utlbU0,
  output logic               isrdNotWrt,
  output logic [1:0]         isAddr,
  output logic [EPN_W-1:0]   isEPN,
  output logic [EPN_W-1:0]   RPN,
  output logic [DSIZE_W-1:0] DSize,
  output logic               E,
  output logic               I,
  output logic               U0,
  output logic               itlbBusy,
  output logic               itlbMissExc,
  output logic               itlbProtExc,
  output logic               refillDone
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  localparam logic [4:0] TO_LAST = 5'(TO_CYC - 1);

  logic [2:0]         state_q,       state_d;
  logic [EPN_W-1:0]   epn_q,         epn_d;
  logic               utlb_req_q,    utlb_req_d;
  logic [4:0]         timeout_q,     timeout_d;
  logic [1:0]         victim_q,      victim_d;
  logic               rd_not_wrt_q,  rd_not_wrt_d;
  logic [1:0]         is_addr_q,     is_addr_d;
  logic [EPN_W-1:0]   rpn_q,         rpn_d;
  logic [DSIZE_W-1:0] dsize_q,       dsize_d;
  logic               e_q,           e_d;
  logic               i_q,           i_d;
  logic               u0_q,          u0_d;
  logic               busy_q,        busy_d;
  logic               refill_done_q, refill_done_d;
  logic               miss_exc_q,    miss_exc_d;
  logic               prot_exc_q,    prot_exc_d;

  logic               qual_miss_s;
  logic               flush_s;
  logic               to_hit_s;
  logic [1:0]         victim_nxt_s;

  assign qual_miss_s = itlbMiss & ifetchValid & msrIR & ~isAbort & ~isInvalidate;
  assign flush_s     = isAbort | isInvalidate;
  assign to_hit_s    = (timeout_q == TO_LAST);

  // Next-state and datapath update for the refill sequence.
  always_comb begin
    state_d       = state_q;
    epn_d         = epn_q;
    utlb_req_d    = utlb_req_q;
    timeout_d     = timeout_q;
    victim_nxt_s  = victim_q;
    rd_not_wrt_d  = 1'b1;
    is_addr_d     = is_addr_q;
    rpn_d         = rpn_q;
    dsize_d       = dsize_q;
    e_d           = e_q;
    i_d           = i_q;
    u0_d          = u0_q;
    refill_done_d = 1'b0;
    miss_exc_d    = 1'b0;
    prot_exc_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timeout_d = 5'd0;
        if (qual_miss_s) begin
          epn_d      = fetchEPN;
          utlb_req_d = 1'b1;
          state_d    = ST_REQ;
        end else begin
          utlb_req_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A grant commits us to consuming the response, even if a flush arrives with it.
        if (utlbGnt) begin
          utlb_req_d = 1'b0;
          timeout_d  = 5'd0;
          state_d    = flush_s ? ST_DRAIN : ST_WAIT;
        end else if (flush_s) begin
          utlb_req_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          utlb_req_d = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_WAIT: begin
        timeout_d = timeout_q + 5'd1;
        if (utlbRspVld) begin
          if (flush_s) begin
            state_d = ST_IDLE;
          end else if (utlbHit && utlbEX) begin
            rpn_d        = utlbRPN;
            dsize_d      = utlbDSize;
            e_d          = utlbE;
            i_d          = utlbI;
            u0_d         = utlbU0;
            rd_not_wrt_d = 1'b0;
            is_addr_d    = victim_q;
            state_d      = ST_WRITE;
          end else if (utlbHit) begin
            prot_exc_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            miss_exc_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (to_hit_s) begin
          state_d = ST_IDLE;
        end else if (flush_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        timeout_d = timeout_q + 5'd1;
        if (utlbRspVld || to_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_WRITE: begin
        // The write strobe is gated by invalidate at the output, so completion must be too.
        if (isInvalidate) begin
          refill_done_d = 1'b0;
        end else begin
          refill_done_d = 1'b1;
          victim_nxt_s  = victim_q + 2'd1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        utlb_req_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    victim_d = isInvalidate ? 2'd0 : victim_nxt_s;
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CB or negedge coreReset_N) begin
    if (!coreReset_N) begin
      state_q       <= ST_IDLE;
      epn_q         <= '0;
      utlb_req_q    <= 1'b0;
      timeout_q     <= 5'd0;
      victim_q      <= 2'd0;
      rd_not_wrt_q  <= 1'b1;
      is_addr_q     <= 2'd0;
      rpn_q         <= '0;
      dsize_q       <= '0;
      e_q           <= 1'b0;
      i_q           <= 1'b0;
      u0_q          <= 1'b0;
      busy_q        <= 1'b0;
      refill_done_q <= 1'b0;
      miss_exc_q    <= 1'b0;
      prot_exc_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      epn_q         <= epn_d;
      utlb_req_q    <= utlb_req_d;
      timeout_q     <= timeout_d;
      victim_q      <= victim_d;
      rd_not_wrt_q  <= rd_not_wrt_d;
      is_addr_q     <= is_addr_d;
      rpn_q         <= rpn_d;
      dsize_q       <= dsize_d;
      e_q           <= e_d;
      i_q           <= i_d;
      u0_q          <= u0_d;
      busy_q        <= busy_d;
      refill_done_q <= refill_done_d;
      miss_exc_q    <= miss_exc_d;
      prot_exc_q    <= prot_exc_d;
    end
  end

  assign utlbReq     = utlb_req_q;
  assign utlbEPN     = epn_q;
  assign isEPN       = epn_q;
  assign isrdNotWrt  = rd_not_wrt_q | isInvalidate;
  assign isAddr      = is_addr_q;
  assign RPN         = rpn_q;
  assign DSize       = dsize_q;
  assign E           = e_q;
  assign I           = i_q;
  assign U0          = u0_q;
  assign itlbBusy    = busy_q;
  assign itlbMissExc = miss_exc_q;
  assign itlbProtExc = prot_exc_q;
  assign refillDone  = refill_done_q;

endmodule

// File: tb/tb_p405s_itlb_refill_ctl.sv
// Scoreboard bench for the ITLB refill sequencer: stimulus queues expected events,
// a negedge monitor pops and checks them as the DUT raises them.
module tb_p405s_itlb_refill_ctl;

  localparam int K_WRITE = 0;
  localparam int K_DONE  = 1;
  localparam int K_MISS  = 2;
  localparam int K_PROT  = 3;

  logic        CB = 1'b0;
  logic        coreReset_N;
  logic        itlbMiss, ifetchValid, msrIR, isAbort, isInvalidate;
  logic [21:0] fetchEPN;
  logic        utlbReq, utlbGnt, utlbRspVld, utlbHit, utlbEX;
  logic [21:0] utlbEPN, utlbRPN;
  logic [6:0]  utlbDSize;
  logic        utlbE, utlbI, utlbU0;
  logic        isrdNotWrt;
  logic [1:0]  isAddr;
  logic [21:0] isEPN, RPN;
  logic [6:0]  DSize;
  logic        E, I, U0;
  logic        itlbBusy, itlbMissExc, itlbProtExc, refillDone;

  typedef struct {
    int          kind;
    logic [1:0]  addr;
    logic [21:0] rpn;
    logic [21:0] epn;
    logic [6:0]  ds;
    logic [2:0]  attr;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  p405s_itlb_refill_ctl dut (
    .CB(CB), .coreReset_N(coreReset_N),
    .itlbMiss(itlbMiss), .ifetchValid(ifetchValid), .msrIR(msrIR), .fetchEPN(fetchEPN),
    .isAbort(isAbort), .isInvalidate(isInvalidate),
    .utlbReq(utlbReq), .utlbGnt(utlbGnt), .utlbEPN(utlbEPN),
    .utlbRspVld(utlbRspVld), .utlbHit(utlbHit), .utlbEX(utlbEX), .utlbRPN(utlbRPN),
    .utlbDSize(utlbDSize), .utlbE(utlbE), .utlbI(utlbI), .utlbU0(utlbU0),
    .isrdNotWrt(isrdNotWrt), .isAddr(isAddr), .isEPN(isEPN), .RPN(RPN), .DSize(DSize),
    .E(E), .I(I), .U0(U0),
    .itlbBusy(itlbBusy), .itlbMissExc(itlbMissExc), .itlbProtExc(itlbProtExc),
    .refillDone(refillDone)
  );

  always #5 CB = ~CB;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CB);
    #1;
  endtask

  task automatic push(input int kind, input logic [1:0] addr, input logic [21:0] rpn,
                      input logic [21:0] epn, input logic [6:0] ds, input logic [2:0] attr);
    exp_t x;
    x.kind = kind; x.addr = addr; x.rpn = rpn; x.epn = epn; x.ds = ds; x.attr = attr;
    expq.push_back(x);
  endtask

  task automatic mon_event(input int kind);
    exp_t x;
    if (expq.size() == 0) begin
      chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      x = expq.pop_front();
      chk("event_kind", 32'(kind), 32'(x.kind));
      if (kind == K_WRITE && x.kind == K_WRITE) begin
        chk("wr_addr",  32'(isAddr), 32'(x.addr));
        chk("wr_rpn",   32'(RPN),    32'(x.rpn));
        chk("wr_epn",   32'(isEPN),  32'(x.epn));
        chk("wr_dsize", 32'(DSize),  32'(x.ds));
        chk("wr_attr",  32'({E, I, U0}), 32'(x.attr));
      end
    end
  endtask

  // Monitor: every DUT-raised event consumes exactly one scoreboard entry.
  always @(negedge CB) begin
    if (coreReset_N === 1'b1) begin
      if (isrdNotWrt === 1'b0) mon_event(K_WRITE);
      if (refillDone === 1'b1) mon_event(K_DONE);
      if (itlbMissExc === 1'b1) mon_event(K_MISS);
      if (itlbProtExc === 1'b1) mon_event(K_PROT);
    end
  end

  // Full refill: miss, grant after gdly cycles, response rdly cycles after grant.
  task automatic refill(input logic [21:0] epn, input int gdly, input int rdly,
                        input bit hit, input bit ex, input logic [21:0] rpn,
                        input logic [6:0] ds, input logic [2:0] attr,
                        input logic [1:0] exp_addr, input bit inv_in_write);
    fetchEPN = epn; itlbMiss = 1'b1;
    step();
    itlbMiss = 1'b0;
    chk("req_asserted", 32'(utlbReq), 32'd1);
    chk("req_epn", 32'(utlbEPN), 32'(epn));
    repeat (gdly - 1) step();
    utlbGnt = 1'b1;
    step();
    utlbGnt = 1'b0;
    chk("req_dropped_after_gnt", 32'(utlbReq), 32'd0);
    chk("busy_in_wait", 32'(itlbBusy), 32'd1);
    repeat (rdly - 1) step();
    if (hit && ex && !inv_in_write) begin
      push(K_WRITE, exp_addr, rpn, epn, ds, attr);
      push(K_DONE, 2'd0, 22'd0, 22'd0, 7'd0, 3'd0);
    end else if (hit && !ex) begin
      push(K_PROT, 2'd0, 22'd0, 22'd0, 7'd0, 3'd0);
    end else if (!hit) begin
      push(K_MISS, 2'd0, 22'd0, 22'd0, 7'd0, 3'd0);
    end
    utlbRspVld = 1'b1; utlbHit = hit; utlbEX = ex; utlbRPN = rpn; utlbDSize = ds;
    {utlbE, utlbI, utlbU0} = attr;
    step();
    utlbRspVld = 1'b0;
    if (inv_in_write) begin
      isInvalidate = 1'b1;
      step();
      isInvalidate = 1'b0;
    end
    repeat (3) step();
    chk("idle_after_refill", 32'(itlbBusy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    coreReset_N = 1'b0;
    itlbMiss = 1'b0; ifetchValid = 1'b1; msrIR = 1'b1; fetchEPN = 22'd0;
    isAbort = 1'b0; isInvalidate = 1'b0; utlbGnt = 1'b0; utlbRspVld = 1'b0;
    utlbHit = 1'b0; utlbEX = 1'b0; utlbRPN = 22'd0; utlbDSize = 7'd0;
    utlbE = 1'b0; utlbI = 1'b0; utlbU0 = 1'b0;
    repeat (3) step();
    chk("rst_utlbReq", 32'(utlbReq), 32'd0);
    chk("rst_isrdNotWrt", 32'(isrdNotWrt), 32'd1);
    chk("rst_isAddr", 32'(isAddr), 32'd0);
    chk("rst_busy", 32'(itlbBusy), 32'd0);
    chk("rst_pulses", 32'({refillDone, itlbMissExc, itlbProtExc}), 32'd0);
    chk("rst_rpn", 32'(RPN), 32'd0);
    coreReset_N = 1'b1;
    repeat (2) step();

    // Basic successful refill into victim 0.
    refill(22'h12345, 2, 3, 1'b1, 1'b1, 22'h2ABCD, 7'h00, 3'b100, 2'd0, 1'b0);
    // Protection fault then UTLB miss: no writes, victim stays at 1.
    refill(22'h00111, 1, 2, 1'b1, 1'b0, 22'h3FFFF, 7'h7F, 3'b111, 2'd0, 1'b0);
    refill(22'h00222, 1, 2, 1'b0, 1'b1, 22'h3FFFF, 7'h7F, 3'b111, 2'd0, 1'b0);
    refill(22'h3C0DE, 1, 1, 1'b1, 1'b1, 22'h15555, 7'h3F, 3'b011, 2'd1, 1'b0);

    // Abort right after grant: busy until the response, which is then dropped.
    fetchEPN = 22'h0ABCD; itlbMiss = 1'b1;
    step();
    itlbMiss = 1'b0;
    utlbGnt = 1'b1;
    step();
    utlbGnt = 1'b0; isAbort = 1'b1;
    step();
    isAbort = 1'b0;
    repeat (3) step();
    chk("drain_busy", 32'(itlbBusy), 32'd1);
    utlbRspVld = 1'b1; utlbHit = 1'b1; utlbEX = 1'b1;
    step();
    utlbRspVld = 1'b0;
    chk("drain_done_idle", 32'(itlbBusy), 32'd0);
    repeat (2) step();

    // Timeout: 31 silent WAIT cycles, then the held miss re-requests.
    fetchEPN = 22'h00777; itlbMiss = 1'b1;
    step();
    utlbGnt = 1'b1;
    step();
    utlbGnt = 1'b0;
    repeat (30) step();
    chk("to_still_busy", 32'(itlbBusy), 32'd1);
    step();
    chk("to_idle", 32'(itlbBusy), 32'd0);
    step();
    chk("to_retry_req", 32'(utlbReq), 32'd1);
    itlbMiss = 1'b0;
    utlbGnt = 1'b1;
    step();
    utlbGnt = 1'b0;
    step();
    push(K_MISS, 2'd0, 22'd0, 22'd0, 7'd0, 3'd0);
    utlbRspVld = 1'b1; utlbHit = 1'b0;
    step();
    utlbRspVld = 1'b0;
    repeat (3) step();

    // Invalidate in the WRITE cycle at victim 2: no write, victim back to 0.
    refill(22'h01234, 1, 1, 1'b1, 1'b1, 22'h0F0F0, 7'h01, 3'b010, 2'd2, 1'b1);

    // Five back-to-back refills walk the victim 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      refill(22'h20000 + 22'(k), 1, 1, 1'b1, 1'b1, 22'h10000 + 22'(k), 7'(k), 3'(k),
             2'(k % 4), 1'b0);
    end

    // Reset while in WAIT: immediate clear, late response ignored, victim back to 0.
    fetchEPN = 22'h0BEEF; itlbMiss = 1'b1;
    step();
    itlbMiss = 1'b0;
    utlbGnt = 1'b1;
    step();
    utlbGnt = 1'b0;
    #1;
    coreReset_N = 1'b0;
    #1;
    chk("midrst_req", 32'(utlbReq), 32'd0);
    chk("midrst_busy", 32'(itlbBusy), 32'd0);
    step();
    coreReset_N = 1'b1;
    utlbRspVld = 1'b1; utlbHit = 1'b1; utlbEX = 1'b1;
    step();
    utlbRspVld = 1'b0;
    chk("postrst_idle", 32'(itlbBusy), 32'd0);
    refill(22'h0CAFE, 1, 2, 1'b1, 1'b1, 22'h3ABCD, 7'h0F, 3'b101, 2'd0, 1'b0);

    repeat (5) step();
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/p405s_itlb_refill_ctl.md
Name: p405s_itlb_refill_ctl

Overview:
Refill sequencer on the write side of the 4-entry instruction shadow TLB. On a qualified shadow-TLB miss it requests the unified TLB (UTLB), waits for the translation, then runs one write cycle into the victim shadow word using the shadow TLB's isrdNotWrt/isAddr write interface. UTLB misses and execute violations are reported as single-cycle exception pulses. The block sits between the shadow TLB, the UTLB arbiter and the fetch exception logic.

Parameters:
EPN_W, 22, effective/real page number width.
DSIZE_W, 7, page-size mask width.
TO_CYC, 31, cycles in WAIT with no UTLB response before giving up (5-bit counter, 1..31).

Ports:
CB  in  1  clock
coreReset_N  in  1  asynchronous active-low reset
itlbMiss  in  1  shadow-TLB miss (all four words missed)
ifetchValid  in  1  fetch request valid this cycle
msrIR  in  1  instruction relocation enabled
fetchEPN  in  EPN_W  EPN of the missing fetch
isAbort  in  1  fetch abort / flush
isInvalidate  in  1  invalidate all shadow entries (isync/tlbia)
utlbReq  out  1  UTLB search request
utlbGnt  in  1  UTLB arbiter grant
utlbEPN  out  EPN_W  EPN presented to UTLB
utlbRspVld  in  1  UTLB response valid (1 cycle)
utlbHit  in  1  UTLB hit
utlbEX  in  1  execute permission
utlbRPN  in  EPN_W  translated RPN
utlbDSize  in  DSIZE_W  page-size mask
utlbE, utlbI, utlbU0  in  1 each  storage attributes
isrdNotWrt  out  1  0 = shadow write cycle
isAddr  out  2  shadow word select
isEPN  out  EPN_W  EPN written to shadow
RPN  out  EPN_W  RPN written to shadow
DSize  out  DSIZE_W  size mask written to shadow
E, I, U0  out  1 each  attributes written to shadow
itlbBusy  out  1  refill in progress (state != IDLE)
itlbMissExc  out  1  pulse: UTLB miss
itlbProtExc  out  1  pulse: execute violation
refillDone  out  1  pulse: shadow entry written

Behaviour:
- Reset (async): state IDLE, utlbReq=0, isrdNotWrt=1, isAddr=0, victim=0, timeout=0, all data regs and pulse outputs 0.
- Qualified miss = itlbMiss & ifetchValid & msrIR & ~isAbort & ~isInvalidate.
- IDLE: on qualified miss capture fetchEPN into epnReg and go REQ. utlbEPN = isEPN = epnReg at all times.
- REQ: utlbReq=1 (registered, asserts the cycle after capture). On utlbGnt -> WAIT; utlbReq deasserts the next cycle. isAbort/isInvalidate in REQ with no grant -> IDLE, no pulse.
- WAIT: timeout counts up from 0 each cycle. On utlbRspVld: hit&EX -> latch RPN/DSize/E/I/U0, go WRITE; hit&~EX -> itlbProtExc=1 for 1 cycle, IDLE; ~hit -> itlbMissExc=1 for 1 cycle, IDLE. Counter reaching TO_CYC with no response -> IDLE, no pulse; the fetch re-misses and retries.
- Abort in WAIT -> DRAIN: remain until utlbRspVld (or timeout), discard the response, no pulse, then IDLE. A granted request is never abandoned mid-flight.
- WRITE (exactly 1 cycle): isrdNotWrt=0, isAddr=victim, data outputs hold the latched values. Next cycle: refillDone=1, victim=victim+1 mod 4 (3 wraps to 0), IDLE.
- isAbort during WRITE: the write still completes. isInvalidate during WRITE: write suppressed (isrdNotWrt stays 1), no refillDone, victim reset to 0, IDLE.
- isInvalidate in any state resets victim to 0. Same-cycle invalidate and completion: invalidate wins.
- Pulse outputs are registered and never overlap. At most one pulse per refill.
- A new miss is accepted no earlier than the cycle after the state returns to IDLE.
- Reset asserted mid-refill returns everything to reset values immediately. A pending grant or response is ignored after reset.

Test Plan:
- Miss EPN=0x12345, grant after 2 cycles, response 3 cycles later hit/EX, RPN=0x2ABCD, E=1 -> isrdNotWrt=0 for exactly 1 cycle with isAddr=0, RPN=0x2ABCD, isEPN=0x12345; refillDone next cycle; victim=1.
- Five back-to-back successful refills -> isAddr sequence 0,1,2,3,0.
- Response hit with EX=0 -> itlbProtExc 1-cycle pulse, no write, victim unchanged. Response ~hit -> itlbMissExc pulse only.
- isAbort the cycle after grant, response arrives 4 cycles later -> itlbBusy held until the response, no write, no pulse, then IDLE.
- No response for TO_CYC=31 cycles -> IDLE with no pulses; the still-present itlbMiss starts a new REQ.
- isInvalidate in the WRITE cycle with victim=2 -> no write strobe, no refillDone, victim=0. coreReset_N low in WAIT -> utlbReq=0 and state IDLE immediately, victim=0.
